// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin codes and coin value lookup for the vending controller
// Contents:
//   state_t      controller states IDLE / CREDIT / VEND / CHANGE
//   COIN_*       coin codes as seen on the acceptor and hopper interfaces
//   coin_val()   maps a coin code to its value given the three configured values
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  function automatic int unsigned coin_val(input logic [1:0] code,
                                           input int unsigned v1,
                                           input int unsigned v2,
                                           input int unsigned v3);
    case (code)
      COIN_1:  return v1;
      COIN_2:  return v2;
      COIN_3:  return v3;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// rtl/vend_change_sel.sv - combinational greedy change coin picker
// Ports:
//   balance  in   BAL_W  credit still owed to the customer
//   code     out  2      largest coin code whose value fits in balance (COIN_NONE if none)
//   value    out  BAL_W  value of that coin
//   valid    out  1      1 when a coin fits
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25
) (
  input  logic [BAL_W-1:0] balance,
  output logic [1:0]       code,
  output logic [BAL_W-1:0] value,
  output logic             valid
);

  localparam logic [BAL_W-1:0] V1 = BAL_W'(COIN1_VAL);
  localparam logic [BAL_W-1:0] V2 = BAL_W'(COIN2_VAL);
  localparam logic [BAL_W-1:0] V3 = BAL_W'(COIN3_VAL);

  always_comb begin
    code  = COIN_NONE;
    value = '0;
    valid = 1'b0;
    if (balance >= V3) begin
      code  = COIN_3;
      value = V3;
      valid = 1'b1;
    end else if (balance >= V2) begin
      code  = COIN_2;
      value = V2;
      valid = 1'b1;
    end else if (balance >= V1) begin
      code  = COIN_1;
      value = V1;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// rtl/vend_fsm_multi.sv - multi-product vending controller with credit, timeout and coin-by-coin change
// Ports:
//   clk, reset (sync, active-high)
//   coin           in   2               coin code from acceptor, 00 = none
//   sel_valid      in   1               product selection strobe
//   sel_id         in   SEL_W           selected product
//   cancel         in   1               refund request
//   price_vec      in   NUM_PROD*BAL_W  per-product price table
//   stock_empty    in   NUM_PROD        per-product sold-out flags
//   chg_ready      in   1               hopper accepts offered coin
//   coin_reject    out  1               pulse: coin not credited
//   sold_out       out  1               pulse: selection refused, no stock
//   need_more      out  1               pulse: selection refused, credit short
//   dispense       out  1               vend pulse
//   dispense_id    out  SEL_W           product vended
//   chg_valid      out  1               change coin offered
//   chg_coin       out  2               offered coin code
//   refund_mode    out  1               change phase entered by cancel/timeout
//   balance        out  BAL_W           current credit
//   busy           out  1               in VEND or CHANGE
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PROD    = 4,
  parameter int unsigned BAL_W       = 8,
  parameter int unsigned MAX_BAL     = 200,
  parameter int unsigned COIN1_VAL   = 5,
  parameter int unsigned COIN2_VAL   = 10,
  parameter int unsigned COIN3_VAL   = 25,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned SEL_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                coin,
  input  logic                      sel_valid,
  input  logic [SEL_W-1:0]          sel_id,
  input  logic                      cancel,
  input  logic [NUM_PROD*BAL_W-1:0] price_vec,
  input  logic [NUM_PROD-1:0]       stock_empty,
  input  logic                      chg_ready,
  output logic                      coin_reject,
  output logic                      sold_out,
  output logic                      need_more,
  output logic                      dispense,
  output logic [SEL_W-1:0]          dispense_id,
  output logic                      chg_valid,
  output logic [1:0]                chg_coin,
  output logic                      refund_mode,
  output logic [BAL_W-1:0]          balance,
  output logic                      busy
);

  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BAL_W:0]    MAX_LIM = (BAL_W+1)'(MAX_BAL);

  state_t            state;
  logic [TO_W-1:0]   idle_cnt;
  logic [BAL_W-1:0]  chg_amt;     // value of the coin currently offered

  logic [BAL_W-1:0]  price_sel;
  logic              sel_sold;
  logic              coin_present;
  logic [BAL_W:0]    coin_sum;
  logic              coin_ok;

  logic [1:0]        pick_code;
  logic [BAL_W-1:0]  pick_val;
  logic              pick_valid;

  // Out-of-range ids match no entry and therefore read as sold out.
  always_comb begin
    price_sel = '0;
    sel_sold  = 1'b1;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      if (sel_id == SEL_W'(i)) begin
        price_sel = price_vec[i*BAL_W +: BAL_W];
        sel_sold  = stock_empty[i];
      end
    end
  end

  // One extra bit so a coin near the ceiling cannot wrap and sneak under MAX_BAL.
  assign coin_present = (coin != COIN_NONE);
  assign coin_sum     = {1'b0, balance} + (BAL_W+1)'(coin_val(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign coin_ok      = (coin_sum <= MAX_LIM);

  vend_change_sel #(
    .BAL_W     (BAL_W),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .COIN3_VAL (COIN3_VAL)
  ) u_change_sel (
    .balance (balance),
    .code    (pick_code),
    .value   (pick_val),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idle_cnt    <= '0;
      chg_amt     <= '0;
      coin_reject <= 1'b0;
      sold_out    <= 1'b0;
      need_more   <= 1'b0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= COIN_NONE;
      refund_mode <= 1'b0;
      balance     <= '0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sold_out    <= 1'b0;
      need_more   <= 1'b0;
      dispense    <= 1'b0;

      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (sel_valid) begin
            if (sel_sold) sold_out  <= 1'b1;
            else          need_more <= 1'b1;
          end
          if (coin_present) begin
            if (coin_ok) begin
              balance <= coin_sum[BAL_W-1:0];
              state   <= ST_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        ST_CREDIT: begin
          if (cancel || (!sel_valid && !coin_present && idle_cnt == TO_LAST)) begin
            coin_reject <= coin_present;
            refund_mode <= 1'b1;
            busy        <= 1'b1;
            idle_cnt    <= '0;
            state       <= ST_CHANGE;
          end else if (sel_valid && !sel_sold && balance >= price_sel) begin
            coin_reject <= coin_present;
            balance     <= balance - price_sel;
            dispense_id <= sel_id;
            dispense    <= 1'b1;
            busy        <= 1'b1;
            idle_cnt    <= '0;
            state       <= ST_VEND;
          end else begin
            // Refused selection: the coin on the same cycle is still handled.
            if (sel_valid) begin
              if (sel_sold) sold_out  <= 1'b1;
              else          need_more <= 1'b1;
            end
            if (coin_present) begin
              if (coin_ok) balance     <= coin_sum[BAL_W-1:0];
              else         coin_reject <= 1'b1;
            end
            if (sel_valid || coin_present) idle_cnt <= '0;
            else                           idle_cnt <= idle_cnt + 1'b1;
          end
        end

        ST_VEND: begin
          coin_reject <= coin_present;
          if (balance != '0) begin
            state <= ST_CHANGE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_CHANGE: begin
          coin_reject <= coin_present;
          if (chg_valid) begin
            if (chg_ready) begin
              chg_valid <= 1'b0;
              chg_coin  <= COIN_NONE;
              balance   <= balance - chg_amt;
            end
          end else if (pick_valid) begin
            chg_valid <= 1'b1;
            chg_coin  <= pick_code;
            chg_amt   <= pick_val;
          end else begin
            // Nothing left that a coin can pay out; any sub-coin residue is dropped.
            balance     <= '0;
            refund_mode <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
